// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Word-organised data memory answering MEM-stage load/store requests.
// A request is accepted over a valid/ready handshake, the access is performed
// LATENCY cycles later and a single-cycle response carries the read data and
// an address-error flag. Only one transaction is in flight at a time.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  cycles from acceptance to response (>= 1)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   block can accept a request (IDLE)
//   mem_read    load request
//   mem_write   store request
//   address     byte address
//   write_data  store data
//   byte_en     store byte lanes
//   resp_valid  one-cycle response strobe
//   read_data   load result, held between responses
//   addr_err    misaligned / out-of-range flag, held between responses
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_en,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        addr_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Replace the enabled byte lanes of a word with the store data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Misaligned or beyond the last word.
    function automatic logic addr_is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_s;
    logic               commit_s;

    logic               req_rd_q;
    logic               req_wr_q;
    logic [31:0]        req_addr_q;
    logic [31:0]        req_wdata_q;
    logic [3:0]         req_be_q;

    logic [31:0]        mem_q [DEPTH];

    logic               resp_valid_q;
    logic               req_ready_q;
    logic [31:0]        read_data_q;
    logic               addr_err_q;

    logic               src_rd_s;
    logic               src_wr_s;
    logic [31:0]        src_addr_s;
    logic [31:0]        src_wdata_s;
    logic [3:0]         src_be_s;
    logic [AW-1:0]      idx_s;
    logic               err_s;
    logic [31:0]        old_word_s;

    // Next-state and counter logic of the request FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && (mem_read || mem_write)) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: the access happens at the
                        // acceptance edge itself, straight from the inputs.
                        state_d  = RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Access source: live inputs when committing from IDLE, latched otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            src_rd_s    = mem_read;
            src_wr_s    = mem_write;
            src_addr_s  = address;
            src_wdata_s = write_data;
            src_be_s    = byte_en;
        end else begin
            src_rd_s    = req_rd_q;
            src_wr_s    = req_wr_q;
            src_addr_s  = req_addr_q;
            src_wdata_s = req_wdata_q;
            src_be_s    = req_be_q;
        end
        idx_s      = src_addr_s[AW+1:2];
        err_s      = addr_is_bad(src_addr_s);
        old_word_s = mem_q[idx_s];
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_be_q    <= 4'd0;
        end else if (accept_s) begin
            req_rd_q    <= mem_read;
            req_wr_q    <= mem_write;
            req_addr_q  <= address;
            req_wdata_q <= write_data;
            req_be_q    <= byte_en;
        end else begin
            req_rd_q    <= req_rd_q;
            req_wr_q    <= req_wr_q;
            req_addr_q  <= req_addr_q;
            req_wdata_q <= req_wdata_q;
            req_be_q    <= req_be_q;
        end
    end

    // Memory array: reset to word i = i, byte-lane store on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'(i);
            end
        end else if (commit_s && src_wr_s && !err_s) begin
            mem_q[idx_s] <= merge_bytes(old_word_s, src_wdata_s, src_be_s);
        end
    end

    // Response and handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            read_data_q  <= 32'd0;
            addr_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= (state_d == RESP);
            req_ready_q  <= (state_d == IDLE);
            if (commit_s) begin
                addr_err_q  <= err_s;
                // Read-before-write: the pre-store word is returned.
                read_data_q <= (err_s || !src_rd_s) ? 32'd0 : old_word_s;
            end else begin
                addr_err_q  <= addr_err_q;
                read_data_q <= read_data_q;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign read_data  = read_data_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [3:0]  byte_en;
    logic        req_ready, resp_valid, addr_err;
    logic [31:0] read_data;

    logic        req_valid1, mem_read1, mem_write1;
    logic [31:0] address1, write_data1;
    logic [3:0]  byte_en1;
    logic        req_ready1, resp_valid1, addr_err1;
    logic [31:0] read_data1;

    data_mem_responder #(.DEPTH(32), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .address(address),
        .write_data(write_data), .byte_en(byte_en), .resp_valid(resp_valid),
        .read_data(read_data), .addr_err(addr_err)
    );

    data_mem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .mem_read(mem_read1), .mem_write(mem_write1), .address(address1),
        .write_data(write_data1), .byte_en(byte_en1), .resp_valid(resp_valid1),
        .read_data(read_data1), .addr_err(addr_err1)
    );

    int errors = 0;
    int checks = 0;

    // Reference memory contents, one entry per word.
    logic [31:0] model [32];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a >= 32'd128);
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        if (!rd || model_err(a)) return 32'd0;
        return model[a / 32'd4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'(i);
    endtask

    task automatic model_apply(input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        if (wr && !model_err(a)) begin
            w = model[a / 32'd4];
            for (int l = 0; l < 4; l++) begin
                if (be[l]) w[8*l +: 8] = wd[8*l +: 8];
            end
            model[a / 32'd4] = w;
        end
    endtask

    // One complete LATENCY=2 transaction with cycle-exact checks.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_data, input logic exp_err,
                           input string tag);
        @(negedge clk);
        chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle resp_valid"}, 32'(resp_valid), 32'd0);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        address = a; write_data = wd; byte_en = be;
        @(posedge clk);
        @(negedge clk);
        // Scramble the fields so latching errors show up.
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = $urandom; write_data = $urandom; byte_en = 4'($urandom);
        chk({tag, " wait ready"}, 32'(req_ready), 32'd0);
        chk({tag, " wait resp_valid"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp ready"}, 32'(req_ready), 32'd0);
        chk({tag, " addr_err"}, 32'(addr_err), 32'(exp_err));
        if (rd || exp_err) chk({tag, " read_data"}, read_data, exp_data);
    endtask

    initial begin
        logic        r_rd, r_wr, e_err;
        logic [31:0] r_addr, r_wd, e_data;
        logic [3:0]  r_be;
        int          sel;

        rst = 1'b1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = 32'd0; write_data = 32'd0; byte_en = 4'd0;
        req_valid1 = 1'b0; mem_read1 = 1'b0; mem_write1 = 1'b0;
        address1 = 32'd0; write_data1 = 32'd0; byte_en1 = 4'd0;
        model_reset();

        vecs[0] = '{1'b1, 1'b0, 32'h0C, 32'h0,        4'h0, 32'h3,        1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h14, 32'h0,        4'h0, 32'h5,        1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h08, 32'h0,        4'h0, 32'h00BB00DD, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h06, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h04, 32'h1234,     4'hF, 32'h1,        1'b0};
        vecs[9] = '{1'b1, 1'b0, 32'h04, 32'h0,        4'h0, 32'h1234,     1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset read_data", read_data, 32'd0);
        chk("reset addr_err", 32'(addr_err), 32'd0);
        chk("reset1 req_ready", 32'(req_ready1), 32'd1);
        chk("reset1 resp_valid", 32'(resp_valid1), 32'd0);
        rst = 1'b0;

        // Non-transaction: valid without read/write is ignored.
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        chk("noop ready", 32'(req_ready), 32'd1);
        chk("noop resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
            model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
        end

        // Whole-array sweep: the failed 0x80 store must not have touched anything.
        for (int i = 0; i < 32; i++) begin
            run_req(1'b1, 1'b0, 32'(i * 4), 32'd0, 4'd0, model[i], 1'b0,
                    $sformatf("sweep%0d", i));
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) r_addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else if (sel == 1) begin
                r_addr = $urandom & 32'hFFFF_FFFC;
                if (r_addr < 32'd128) r_addr = r_addr + 32'd128;
            end else r_addr = 32'($urandom_range(0, 31) * 4);
            sel  = $urandom_range(1, 3);
            r_rd = sel[0];
            r_wr = sel[1];
            r_wd = $urandom;
            r_be = 4'($urandom);
            e_err  = model_err(r_addr);
            e_data = model_read(r_rd, r_addr);
            run_req(r_rd, r_wr, r_addr, r_wd, r_be, e_data, e_err, $sformatf("rand%0d", n));
            model_apply(r_wr, r_addr, r_wd, r_be);
        end

        // Reset while a store is waiting.
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        address = 32'h0; write_data = 32'hFFFFFFFF; byte_en = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; mem_write = 1'b0;
        rst = 1'b1;
        chk("midrst wait resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst resp_valid", 32'(resp_valid), 32'd0);
        chk("postrst ready", 32'(req_ready), 32'd1);
        model_reset();
        run_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, "postrst word0");

        // LATENCY=1 back-to-back reads with req_valid held high.
        @(negedge clk);
        chk("l1 ready0", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1; mem_read1 = 1'b1; address1 = 32'h0;
        @(negedge clk);
        chk("l1 resp0 valid", 32'(resp_valid1), 32'd1);
        chk("l1 resp0 data", read_data1, 32'd0);
        chk("l1 resp0 err", 32'(addr_err1), 32'd0);
        chk("l1 ready1", 32'(req_ready1), 32'd0);
        address1 = 32'h4;
        @(negedge clk);
        chk("l1 gap valid", 32'(resp_valid1), 32'd0);
        chk("l1 ready2", 32'(req_ready1), 32'd1);
        chk("l1 gap data hold", read_data1, 32'd0);
        @(negedge clk);
        chk("l1 resp1 valid", 32'(resp_valid1), 32'd1);
        chk("l1 resp1 data", read_data1, 32'd1);
        req_valid1 = 1'b0; mem_read1 = 1'b0;
        @(negedge clk);
        chk("l1 end valid", 32'(resp_valid1), 32'd0);
        chk("l1 end data hold", read_data1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-organised data memory: the responding end of the MEM-stage load/store interface.
- The MEM stage issues read and write requests over a valid/ready handshake.
- This block performs the access after a fixed, parameterised latency and returns a one-cycle response carrying the read data and an address-error flag.
- It sits between the MEM stage and the WB path and replaces the MEM stage's inline memory array.

Parameters:
- DEPTH, 32, number of 32-bit words; must be a power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to response; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- mem_read  input  1  load request, m[1] equivalent.
- mem_write  input  1  store request, m[0] equivalent.
- address  input  32  byte address.
- write_data  input  32  store data.
- byte_en  input  4  store byte lanes; bit i enables write_data[8i+7:8i].
- resp_valid  output  1  one-cycle response strobe.
- read_data  output  32  load result; valid while resp_valid is high.
- addr_err  output  1  misaligned or out-of-range access; valid while resp_valid is high.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE; req_ready=1, resp_valid=0, read_data=0, addr_err=0.
  - Latency counter is 0.
  - Memory word i is initialised to value i, for i = 0..DEPTH-1.
- Reset mid-transaction: the pending request is dropped, no write is committed and no response is issued.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Acceptance occurs at an edge where req_valid & req_ready & (mem_read | mem_write) is true.
  - On acceptance, the block latches mem_read, mem_write, address, write_data and byte_en.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with the counter loaded to LATENCY-2.
  - A req_valid with neither mem_read nor mem_write set is not a transaction: stay in IDLE, no response.
  - WAIT: req_ready=0. Decrement the counter each cycle; when it reaches 0, go to RESP.
  - Entering RESP registers the access: read_data, addr_err and the memory update all take effect at the same edge.
  - RESP: resp_valid=1 and req_ready=0 for exactly one cycle, then return to IDLE.
- Latency and throughput:
  - A request accepted at edge k has resp_valid high between edges k+LATENCY-1 and k+LATENCY.
  - No overlap between transactions: at most one request per LATENCY+1 cycles.
- Addressing:
  - Word index is address[log2(DEPTH)+1:2].
  - addr_err=1 if address[1:0] != 0 (misaligned) or address >= 4*DEPTH (out of range).
  - On addr_err: no memory write occurs, read_data=0, and the response is still issued.
- Read: read_data is the word contents before any same-request write (read-before-write).
- Write: only the lanes enabled in byte_en are updated. byte_en=0 is a legal no-op write that still responds.
- Read and write together: read_data returns the old word and the write is committed.
- Outputs between responses:
  - read_data and addr_err hold their last response values while resp_valid=0.
  - resp_valid is never high for more than one consecutive cycle.
- Inputs while req_ready=0 are ignored. The initiator must hold req_valid and the request fields until acceptance.

Test Plan:
- Reset then load, LATENCY=2: reset; read address 0x0C at edge k -> req_ready=0 at k+1; resp_valid=1 in cycle k+1..k+2; read_data=3, addr_err=0.
- Full store then load: write 0xDEADBEEF to 0x10 with byte_en=4'hF; then read 0x10 -> read_data=0xDEADBEEF. Word 5 still reads 5.
- Byte-lane store: word 2 holds 0x00000002; write 0xAABBCCDD to 0x08 with byte_en=4'b0101 -> read 0x08 returns 0x00BB00DD... corrected: 0x00BB00DD has lanes 0 and 2 from write data, so the required result is 0x00BB00DD with lanes 1 and 3 from the old word (0x00 and 0x00).
- Errors:
  - Read 0x06 -> addr_err=1, read_data=0.
  - Write 0x80 (DEPTH=32) -> addr_err=1, and all 32 words remain unchanged.
- Simultaneous read and write: mem_read=mem_write=1 at 0x04, data 0x1234, byte_en=4'hF -> read_data=1 (old value); a following read returns 0x1234.
- Reset mid-transaction: accept a write of 0xFFFFFFFF to 0x00, then assert rst during WAIT -> no resp_valid; afterwards word 0 reads 0 and req_ready=1 the cycle after reset.
- LATENCY=1 back-to-back: hold req_valid with reads at 0x00 then 0x04 -> responses in consecutive-but-one cycles with read_data=0 and 1; req_ready toggles 1,0,1.
